imem_loader: RTL and testbench

Boot-time program loader that fills instruction memory before the pipelined CPU starts. It receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words. It writes each word into instruction memory at consecutive even byte addresses and holds the CPU in reset until the image is complete and verified. It is the write-side counterpart of the CPU's instruction fetch path.

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that receives a framed byte stream
// (SYNC_BYTE, LEN_HI, LEN_LO, N big-endian 16-bit words[, CHK]), writes
// each word to instruction memory at consecutive even byte addresses, and
// holds the CPU in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing CHK byte (XOR of length and data bytes) is verified before DONE.
module imem_loader #(
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LEN_HI  = 4'd1;
  localparam logic [3:0] LEN_LO  = 4'd2;
  localparam logic [3:0] DATA_HI = 4'd3;
  localparam logic [3:0] DATA_LO = 4'd4;
  localparam logic [3:0] WRITE   = 4'd5;
  localparam logic [3:0] CHECK   = 4'd6;
  localparam logic [3:0] DONE    = 4'd7;
  localparam logic [3:0] ERROR   = 4'd8;

  localparam logic [15:0] MAX_LEN = MAX_WORDS[15:0];

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Image body is followed by the CHK byte.
  localparam logic [3:0] AFTER_BODY = CHECK;
`else
  // No CHK byte: the image is complete as soon as the body is written.
  localparam logic [3:0] AFTER_BODY = DONE;
`endif

  logic [3:0]  state_reg, state_next;
  logic [7:0]  len_hi_reg;
  logic [15:0] len_reg;
  logic [7:0]  hi_reg;
  logic [7:0]  chk_reg;
  logic        im_we_reg;
  logic [15:0] im_addr_reg;
  logic [15:0] im_wdata_reg;
  logic        cpu_hold_reg;
  logic        done_reg;
  logic        error_reg;
  logic [1:0]  err_code_reg;
  logic [15:0] words_loaded_reg;

  logic        accept;
  logic [15:0] len_in;

  assign accept = rx_valid && rx_ready;
  assign len_in = {len_hi_reg, rx_data};

  assign im_we        = im_we_reg;
  assign im_addr      = im_addr_reg;
  assign im_wdata     = im_wdata_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign err_code     = err_code_reg;
  assign words_loaded = words_loaded_reg;

  // Next-state decode and byte acceptance (rx_ready depends on state only).
  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_in > MAX_LEN)      state_next = ERROR;
          else if (len_in == 16'd0)  state_next = AFTER_BODY;
          else                       state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = WRITE;
      end
      WRITE: begin
        // words_loaded_reg still holds the pre-increment count here.
        if ((words_loaded_reg + 16'd1) < len_reg) state_next = DATA_HI;
        else                                      state_next = AFTER_BODY;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == chk_reg) state_next = DONE;
          else                    state_next = ERROR;
        end
      end
`endif
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath: length/byte capture, running checksum, write port and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_reg       <= 8'd0;
      len_reg          <= 16'd0;
      hi_reg           <= 8'd0;
      chk_reg          <= 8'd0;
      im_we_reg        <= 1'b0;
      im_addr_reg      <= 16'd0;
      im_wdata_reg     <= 16'd0;
      cpu_hold_reg     <= 1'b1;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      err_code_reg     <= 2'b00;
      words_loaded_reg <= 16'd0;
    end else begin
      im_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Checksum restarts with every new frame; the sync byte is excluded.
          if (accept && (rx_data == SYNC_BYTE)) chk_reg <= 8'd0;
        end
        LEN_HI: begin
          if (accept) begin
            len_hi_reg <= rx_data;
            chk_reg    <= chk_reg ^ rx_data;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_reg <= len_in;
            chk_reg <= chk_reg ^ rx_data;
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_reg  <= rx_data;
            chk_reg <= chk_reg ^ rx_data;
          end
        end
        DATA_LO: begin
          // Write is presented in the WRITE cycle that follows this handshake.
          if (accept) begin
            im_we_reg    <= 1'b1;
            im_addr_reg  <= {words_loaded_reg[14:0], 1'b0};
            im_wdata_reg <= {hi_reg, rx_data};
            chk_reg      <= chk_reg ^ rx_data;
          end
        end
        WRITE: begin
          words_loaded_reg <= words_loaded_reg + 16'd1;
        end
        default: ;
      endcase

      if ((state_next == DONE) && (state_reg != DONE)) begin
        done_reg     <= 1'b1;
        cpu_hold_reg <= 1'b0;
      end

      if ((state_next == ERROR) && (state_reg != ERROR)) begin
        error_reg    <= 1'b1;
        err_code_reg <= (state_reg == CHECK) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued when a
// frame is issued and popped by an independent write monitor.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Write monitor: every im_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", im_addr, im_wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {im_addr, im_wdata}, e);
        $display("write addr %h data %h", im_addr, im_wdata);
      end
      check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rx_ready) ok = 1;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte %h not accepted, required accept within 50 cycles", d);
    end
  endtask

  task automatic send_frame(input bq_t f, input bit gaps);
    foreach (f[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) step();
      send_byte(f[i]);
    end
  endtask

  task automatic check_reset_values();
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_addr", {16'd0, im_addr}, 32'd0);
    check("rst_im_wdata", {16'd0, im_wdata}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    step();
    check_reset_values();
    rst = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [15:0] nw);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, nw});
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic push_two_words();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
  endtask

  // A5 00 02 12 34 AB CD [chk]
  function automatic bq_t two_word_frame(input logic [7:0] chk);
    bq_t f;
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(chk);
`endif
    return f;
  endfunction

  // After the last frame byte: with CHK the result is visible immediately,
  // otherwise one WRITE cycle intervenes before DONE.
  task automatic finish_body(input string tag);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_done_not_early"}, {31'd0, done}, 32'd0);
    step();
`endif
    check({tag, "_after_body"}, 32'd1, 32'd1 & {31'd0, (done | error)});
  endtask

  initial begin
    bq_t f;

    // Test 1: two-word load, rx_valid held high.
    do_reset();
    push_two_words();
    send_frame(two_word_frame(8'h42), 1'b0);
    finish_body("two_word");
    check_done("two_word", 16'd2);
    $display("two_word load: done=%0d words=%0d", done, words_loaded);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 2: checksum mismatch.
    do_reset();
    push_two_words();
    send_frame(two_word_frame(8'h43), 1'b0);
    check("chkfail_error", {31'd0, error}, 32'd1);
    check("chkfail_err_code", {30'd0, err_code}, 32'd2);
    check("chkfail_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("chkfail_done", {31'd0, done}, 32'd0);
    check("chkfail_pending_writes", exp_q.size(), 32'd0);
    $display("checksum fail: error=%0d err_code=%0d", error, err_code);
`endif

    // Test 3: oversize length 0x0101 > 256.
    do_reset();
    f = '{8'hA5, 8'h01, 8'h01};
    send_frame(f, 1'b0);
    check("oversize_error", {31'd0, error}, 32'd1);
    check("oversize_err_code", {30'd0, err_code}, 32'd1);
    check("oversize_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("oversize_done", {31'd0, done}, 32'd0);
    check("oversize_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (5) step();
    check("oversize_words_loaded", {16'd0, words_loaded}, 32'd0);
    $display("oversize: error=%0d err_code=%0d", error, err_code);

    // Test 4: leading garbage and random rx_valid gaps.
    do_reset();
    push_two_words();
    f = '{8'h00, 8'hFF};
    send_frame(f, 1'b1);
    check("resync_idle_no_error", {31'd0, error}, 32'd0);
    send_frame(two_word_frame(8'h42), 1'b1);
    finish_body("resync");
    check_done("resync", 16'd2);
    $display("resync/backpressure: done=%0d words=%0d", done, words_loaded);

    // Test 5: reset after the first word is written, then a fresh frame.
    do_reset();
    exp_q.push_back({16'h0000, 16'h1234});
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    send_frame(f, 1'b0);
    check("midrst_write_cycle_we", {31'd0, im_we}, 32'd1);
    step();
    check("midrst_words_before", {16'd0, words_loaded}, 32'd1);
    rst = 1'b1;
    step();
    check_reset_values();
    rst = 1'b0;
    push_two_words();
    send_frame(two_word_frame(8'h42), 1'b0);
    finish_body("midrst");
    check_done("midrst", 16'd2);
    $display("reset mid-frame reload: done=%0d words=%0d", done, words_loaded);

    // Test 6: zero-length image.
    do_reset();
    f = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    send_frame(f, 1'b0);
    check_done("zero_len", 16'd0);
    $display("zero length: done=%0d words=%0d", done, words_loaded);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
